mac_result_requant: RTL
=======================

Name: mac_result_requant

Overview:
- Downstream consumer of the 32-bit MAC accumulator result (one dot-product result every 4 clocks).
- Captures each result on a valid strobe, then rescales it with an arithmetic right shift, rounds it, and saturates it to a 16-bit signed word.
- Buffers results in a small FIFO and presents them on a valid/ready stream to the next BDD-accelerator stage.
- Decouples the fixed MAC cadence from a back-pressuring consumer, and flags lost or clipped results.

Parameters:
WIDTH_P, 32, input result width (two's complement)
WIDTH_O, 16, output word width (two's complement)
SHIFT, 8, right-shift amount applied before saturation (0..WIDTH_P-1)
DEPTH, 4, FIFO depth in entries; power of two, at least 2

Ports:
CLK  input  1  rising-edge clock
RST  input  1  asynchronous, active-high reset
P_IN  input  WIDTH_P  accumulator result from the MAC stage
P_VALID  input  1  P_IN is a new result this cycle (single-cycle strobe)
DOUT  output  WIDTH_O  FIFO head word
DOUT_VALID  output  1  FIFO non-empty
DOUT_READY  input  1  consumer accepts DOUT this cycle
LEVEL  output  clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH
SAT_FLAG  output  1  sticky: at least one result was saturated
DROP_FLAG  output  1  sticky: at least one result was lost because the FIFO was full
CLR_FLAGS  input  1  synchronous clear of both sticky flags

Behaviour:
- Clock and reset: one clock (CLK). RST is asynchronous and active-high.
  - While RST is high: DOUT=0, DOUT_VALID=0, LEVEL=0, SAT_FLAG=0, DROP_FLAG=0, FIFO pointers=0, stage-1 valid=0.
  - Asserting RST mid-operation discards the in-flight stage-1 sample and all FIFO contents immediately, without waiting for a clock edge.
- Stage 1 (requantise, registered, 1 cycle): on an edge with P_VALID=1:
  - Compute in WIDTH_P+1 bits: t = sext(P_IN) + (SHIFT>0 ? 2^(SHIFT-1) : 0), then r = t >>> SHIFT (arithmetic shift). This is round-half-up; the extra bit prevents wrap at the positive extreme.
  - If r > 2^(WIDTH_O-1)-1, the result is 2^(WIDTH_O-1)-1 and the sample is marked saturated.
  - If r < -2^(WIDTH_O-1), the result is -2^(WIDTH_O-1) and the sample is marked saturated.
  - Otherwise the result is r[WIDTH_O-1:0].
  - The result, its saturated mark and a valid bit are registered. The stage-1 valid bit is 0 on edges where P_VALID=0.
- Stage 2 (FIFO, DEPTH entries, binary read/write pointers with wrap):
  - push = stage-1 valid. pop = DOUT_VALID & DOUT_READY.
  - Push when not full: write at the write pointer, then advance it. Pop: advance the read pointer. Pop while empty is impossible by construction.
  - Push while full and no pop in the same cycle: the sample is discarded and DROP_FLAG is set.
  - Push and pop in the same cycle while full: both take effect, nothing is dropped, LEVEL is unchanged.
  - Push and pop in the same cycle while empty: the push takes effect and the pop is not possible (DOUT_VALID=0).
  - LEVEL is registered and updates on the same edge as the pointers: +1, -1, or unchanged.
- Output:
  - DOUT = mem[read pointer], read combinationally from the registered array; DOUT_VALID = (LEVEL != 0).
  - DOUT holds stable while DOUT_VALID=1 and DOUT_READY=0.
- Latency: a P_VALID accepted at edge k with the FIFO empty gives DOUT_VALID=1 after edge k+1. Order is strictly FIFO.
- Flags:
  - SAT_FLAG is set on the edge at which a saturated sample is written into the FIFO. Samples dropped for FIFO-full do not set SAT_FLAG.
  - CLR_FLAGS=1 clears both flags at the edge. If a set event occurs in the same cycle, set wins.
- Throughput: accepts one sample per clock indefinitely while DOUT_READY=1. The 4-clock MAC cadence therefore never drops.

Test Plan:
1. Rounding, positive (defaults): P_IN=0x00001280 (4736) with one P_VALID -> DOUT=0x0013 (18.5 rounds up to 19); DOUT_VALID rises after the second edge; LEVEL=1; flags stay 0.
2. Negative values: P_IN=0xFFFFFF80 -> DOUT=0x0000; P_IN=0xFFFFFF7F -> DOUT=0xFFFF; P_IN=0xFFFF8000 -> DOUT=0xFF80; SAT_FLAG stays 0.
3. Saturation: P_IN=0x7FFFFFFF -> DOUT=0x7FFF and SAT_FLAG=1. P_IN=0x80000000 -> DOUT=0x8000. Then CLR_FLAGS pulse -> SAT_FLAG=0. CLR_FLAGS in the same cycle as a new saturated write -> SAT_FLAG=1.
4. Back-pressure: DOUT_READY=0, push 5 samples 1..5 (P_IN=n<<8) -> LEVEL=4 and DROP_FLAG=1. Then DOUT_READY=1 -> DOUT sequence 1,2,3,4, then DOUT_VALID=0.
5. Full with simultaneous push and pop: FIFO full, DOUT_READY=1 and P_VALID on every clock for 8 clocks -> LEVEL stays 4, DROP_FLAG stays 0, output order preserved, pointers wrap correctly.
6. Asynchronous reset: with LEVEL=3 and a stage-1 sample in flight, raise RST between clock edges -> DOUT_VALID=0, LEVEL=0, flags=0 before the next edge. After release, the first new sample appears after 2 edges with the correct value.

Source files
------------

// File: rtl/mac_result_requant.sv
// Requantises 32-bit MAC results (round-half-up shift, 16-bit saturate) into a small output FIFO.
// Latency: result registered one edge after P_VALID, visible on DOUT one edge later.
// Backpressure: DOUT_READY low lets the FIFO fill; a result arriving at a full FIFO is dropped and flagged.
module mac_result_requant #(
    parameter int WIDTH_P = 32,
    parameter int WIDTH_O = 16,
    parameter int SHIFT   = 8,
    parameter int DEPTH   = 4
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [WIDTH_P-1:0]         P_IN,
    input  logic                       P_VALID,
    output logic [WIDTH_O-1:0]         DOUT,
    output logic                       DOUT_VALID,
    input  logic                       DOUT_READY,
    output logic [$clog2(DEPTH):0]     LEVEL,
    output logic                       SAT_FLAG,
    output logic                       DROP_FLAG,
    input  logic                       CLR_FLAGS
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    // Constants held in WIDTH_P+1 bits so the rounding add never wraps.
    localparam logic signed [WIDTH_P:0] RND =
        (SHIFT > 0) ? ({{WIDTH_P{1'b0}}, 1'b1} << (SHIFT - 1)) : '0;
    localparam logic signed [WIDTH_P:0] OMAX =
        {{(WIDTH_P - WIDTH_O + 2){1'b0}}, {(WIDTH_O - 1){1'b1}}};
    localparam logic signed [WIDTH_P:0] OMIN =
        {{(WIDTH_P - WIDTH_O + 2){1'b1}}, {(WIDTH_O - 1){1'b0}}};
    localparam logic [AW-1:0] PTR_ONE = {{(AW - 1){1'b0}}, 1'b1};
    localparam logic [LW-1:0] LVL_ONE = {{(LW - 1){1'b0}}, 1'b1};
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

    logic signed [WIDTH_P:0] rq_sum;
    logic signed [WIDTH_P:0] rq_shf;
    logic [WIDTH_O-1:0]      rq_dat;
    logic                    rq_sat;

    logic                    s1_vld;
    logic [WIDTH_O-1:0]      s1_dat;
    logic                    s1_sat;

    logic [WIDTH_O-1:0]      mem [DEPTH];
    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           rd_ptr;
    logic                    full;
    logic                    pop;
    logic                    wr_en;
    logic                    drop;

    always_comb begin
        rq_sum = $signed({P_IN[WIDTH_P-1], P_IN}) + RND;
        rq_shf = rq_sum >>> SHIFT;
        rq_dat = rq_shf[WIDTH_O-1:0];
        rq_sat = 1'b0;
        if (rq_shf > OMAX) begin
            rq_dat = OMAX[WIDTH_O-1:0];
            rq_sat = 1'b1;
        end else if (rq_shf < OMIN) begin
            rq_dat = OMIN[WIDTH_O-1:0];
            rq_sat = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1_vld <= 1'b0;
            s1_dat <= '0;
            s1_sat <= 1'b0;
        end else begin
            s1_vld <= P_VALID;
            if (P_VALID) begin
                s1_dat <= rq_dat;
                s1_sat <= rq_sat;
            end
        end
    end

    // A full FIFO can still accept a push when the head leaves on the same edge.
    assign full       = (LEVEL == LVL_FULL);
    assign DOUT_VALID = (LEVEL != '0);
    assign pop        = DOUT_VALID & DOUT_READY;
    assign wr_en      = s1_vld & (~full | pop);
    assign drop       = s1_vld & full & ~pop;
    assign DOUT       = mem[rd_ptr];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            LEVEL  <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= s1_dat;
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            if (pop) rd_ptr <= rd_ptr + PTR_ONE;
            case ({wr_en, pop})
                2'b10:   LEVEL <= LEVEL + LVL_ONE;
                2'b01:   LEVEL <= LEVEL - LVL_ONE;
                default: LEVEL <= LEVEL;
            endcase
        end
    end

    // Set takes priority over a coincident clear.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            SAT_FLAG  <= 1'b0;
            DROP_FLAG <= 1'b0;
        end else begin
            if (wr_en && s1_sat) SAT_FLAG <= 1'b1;
            else if (CLR_FLAGS)  SAT_FLAG <= 1'b0;
            if (drop)            DROP_FLAG <= 1'b1;
            else if (CLR_FLAGS)  DROP_FLAG <= 1'b0;
        end
    end

endmodule
